// File: rtl/i4003_loader_if.sv
//------------------------------------------------------------------------------
// i4003_loader_if : valid/ready load-port bundle for the i4003 serial loader
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface i4003_loader_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (output load_data, output load_valid, input load_ready);
  modport slave  (input load_data, input load_valid, output load_ready);
endinterface

`default_nettype wire

// File: rtl/i4003_loader.sv
//------------------------------------------------------------------------------
// i4003_loader : shifts a parallel word MSB-first into a chain of i4003 stages
// with a divided shift clock; optional readback via I4003_LOADER_READBACK_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i4003_loader #(
  parameter int WIDTH  = 10,
  parameter int CP_DIV = 4
) (
  input  wire logic        sysclk,
  input  wire logic        reset_n,
  i4003_loader_if.slave    ld,
  output logic             serial_out,
  output logic             cp,
  output logic             enable,
  output logic             busy,
  output logic             done,
  input  wire logic        serial_return,
  output logic [WIDTH-1:0] readback
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_SHIFT_LO = 2'd1;
  localparam logic [1:0] c_SHIFT_HI = 2'd2;
  localparam logic [1:0] c_FINISH   = 2'd3;

  localparam int c_DIV_W = (CP_DIV > 1) ? $clog2(CP_DIV) : 1;
  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CP_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_BIT_TOP  = c_CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [WIDTH-1:0]   r_shift;
  logic [c_CNT_W-1:0] r_bit;
  logic [c_DIV_W-1:0] r_div;
  logic               r_en_hold;
  logic               w_ready;
  logic               w_accept;
  logic               w_div_last;
  logic               w_last_bit;

  assign w_div_last = (r_div == c_DIV_LAST);
  assign w_last_bit = (r_state == c_SHIFT_HI) && w_div_last && (r_bit == '0);
  assign w_accept   = ld.load_valid && w_ready;

  always_ff @(posedge sysclk) begin
    if (!reset_n) r_state <= c_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:     if (w_accept) w_next = c_SHIFT_LO;
      c_SHIFT_LO: if (w_div_last) w_next = c_SHIFT_HI;
      c_SHIFT_HI: if (w_div_last) w_next = (r_bit == '0) ? c_FINISH : c_SHIFT_LO;
      c_FINISH:   w_next = w_accept ? c_SHIFT_LO : c_IDLE;
      default:    w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    busy    = 1'b0;
    cp      = 1'b0;
    done    = 1'b0;
    case (r_state)
      c_IDLE:     w_ready = 1'b1;
      c_SHIFT_LO: busy    = 1'b1;
      c_SHIFT_HI: begin busy = 1'b1; cp = 1'b1; end
      c_FINISH:   begin w_ready = 1'b1; done = 1'b1; end
      default:    w_ready = 1'b0;
    endcase
  end

  assign ld.load_ready = w_ready;
  assign enable        = done | r_en_hold;
  assign serial_out    = busy & r_shift[WIDTH-1];

  // Shift happens on the HI->LO transition so data is stable around each cp rise.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit     <= '0;
      r_div     <= '0;
      r_en_hold <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= ld.load_data;
      r_bit     <= c_BIT_TOP;
      r_div     <= '0;
      r_en_hold <= 1'b0;
    end else begin
      if (r_state == c_FINISH) r_en_hold <= 1'b1;
      if (busy) begin
        r_div <= w_div_last ? '0 : r_div + 1'b1;
        if ((r_state == c_SHIFT_HI) && w_div_last && (r_bit != '0)) begin
          r_shift <= r_shift << 1;
          r_bit   <= r_bit - 1'b1;
        end
      end
    end
  end

`ifdef I4003_LOADER_READBACK_EN
  logic [WIDTH-1:0] r_rb_shift;
  logic [WIDTH-1:0] r_readback;

  // Sample on the edge that raises cp, i.e. before the 4003 shifts.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_rb_shift <= '0;
      r_readback <= '0;
    end else begin
      if ((r_state == c_SHIFT_LO) && w_div_last)
        r_rb_shift <= (r_rb_shift << 1) | WIDTH'(serial_return);
      if (w_last_bit)
        r_readback <= r_rb_shift;
    end
  end

  assign readback = r_readback;
`else
  logic w_unused_return;
  logic w_unused_last;
  assign w_unused_return = serial_return;
  assign w_unused_last   = w_last_bit;
  assign readback        = '0;
`endif

endmodule

`default_nettype wire

// File: doc/i4003_loader.md
# i4003_loader

Serial transmitter that drives an i4003 shift register from the system clock domain. It accepts a parallel word over a valid/ready handshake, shifts it out MSB-first on `serial_out` with a generated shift clock `cp`, and holds the 4003 output `enable` low during shifting. It sits between system logic (or an I/O-port decoder) and the `serial_in`/`cp`/`enable` pins of an i4003 instance inside the MCS-4 top level.

## Interface

Parameters:
- `WIDTH`, 10: bits per load; legal range 1..32; equals the number of cascaded 4003 stages × 10.
- `CP_DIV`, 4: `sysclk` cycles per `cp` half-period; legal minimum 1.

Ports:
- `sysclk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `load_data`  in  WIDTH  word to shift; `load_data[WIDTH-1]` is sent first and ends in the 4003 Q output farthest from `serial_in`.
- `load_valid`  in  1  request to load `load_data`.
- `load_ready`  out  1  loader idle; transfer occurs when `load_valid && load_ready`.
- `serial_out`  out  1  data to 4003 `serial_in`.
- `cp`  out  1  shift clock to 4003 `cp`; the 4003 samples on the rising edge.
- `enable`  out  1  4003 parallel-output enable.
- `busy`  out  1  shift in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `serial_return`  in  1  4003 `serial_out`; used only with the readback feature.
- `readback`  out  WIDTH  previous 4003 contents; present only with the readback feature.

## Operation

- States: IDLE, SHIFT_LO, SHIFT_HI, FINISH.
- Reset values: `load_ready`=1, `serial_out`=0, `cp`=0, `enable`=0, `busy`=0, `done`=0, `readback`=0. State = IDLE, bit counter = 0, divider = 0.
- IDLE: `load_ready`=1. On handshake, latch `load_data` into the shift register, set bit counter to `WIDTH-1`, drive `enable`=0, and go to SHIFT_LO.
- SHIFT_LO: `cp`=0 and `serial_out` = current MSB. After `CP_DIV` cycles, go to SHIFT_HI.
- SHIFT_HI: `cp`=1 and `serial_out` is unchanged. After `CP_DIV` cycles:
  - If bit counter = 0, go to FINISH.
  - Otherwise shift the register left, decrement the counter, and go to SHIFT_LO.
- FINISH: lasts one cycle. `cp`=0, `enable`=1, `done`=1, `busy`=0, `load_ready`=1. Next state is IDLE.
- `enable` stays 1 from FINISH until the next accepted load, and stays 0 after reset until the first load completes.
- `load_valid` while `load_ready`=0 is ignored; `load_data` is not sampled.
- A handshake in the FINISH cycle is accepted, and the next shift starts the following cycle, so back-to-back loads have no gap.
- `reset_n`=0 mid-shift aborts the shift at the next edge and drives all outputs to reset values. The partial word is discarded and `done` does not pulse.
- `busy` = 1 in SHIFT_LO and SHIFT_HI only.

## Timing

- Handshake accepted at edge T0. Bit k (k=0 is the MSB) occupies cycles T0+1+2k·CP_DIV through T0+2(k+1)·CP_DIV.
- Within each bit, `cp` is low for the first `CP_DIV` cycles and high for the last `CP_DIV` cycles.
- `serial_out` changes only on the cycle `cp` goes low, giving `CP_DIV` cycles of setup and hold around each rising edge.
- `done` and `enable` rise at cycle T0+2·WIDTH·CP_DIV+1. Latency is 81 cycles at the defaults.
- `cp` rising edges per load: exactly `WIDTH`.

## Configuration

- `I4003_LOADER_READBACK_EN` defined:
  - `serial_return` is sampled on the cycle `cp` goes high, before the 4003 shifts.
  - The sample at bit k is stored into `readback[WIDTH-1-k]`.
  - `readback` updates in the FINISH cycle, holds until the next FINISH, and resets to 0.
- Not defined: `serial_return` is unused and `readback` is tied to 0. Sequencing and timing are identical.

## Test plan

- Reset, then idle for 10 cycles -> `load_ready`=1, `enable`=0, `cp`=0, `done`=0 throughout.
- Load 10'h2A5 with defaults -> `serial_out` sequence 1,0,1,0,1,0,0,1,0,1 on 10 `cp` rising edges. `done` pulses at T0+81, `enable`=1 from T0+81, and the attached i4003 `parallel_out` = 10'h2A5.
- Hold `load_valid` high with 10'h3FF then 10'h001 -> second handshake in the FINISH cycle, second word's first `cp` low begins at T0+82, and the final `parallel_out` = 10'h001.
- Assert `reset_n`=0 after 4 `cp` edges of a load -> next cycle all outputs are at reset values, no `done`, and a subsequent load of 10'h155 completes correctly.
- `CP_DIV`=1, `WIDTH`=20, load 20'hABCDE -> latency 41 cycles and 20 `cp` edges.
- With `I4003_LOADER_READBACK_EN` defined, load 10'h2A5 then 10'h0F0 -> `readback` = 10'h2A5 after the second `done`.
